// File: rtl/gcm_msg_sequencer.sv
// Frames one authenticated GCM message: latches lengths, strobes start-of-payload, counts words, times tag check.
// Latency: tag check TAG_LATENCY+1 valid cycles after the last accepted word; o_sop is combinational with the first word.
// Backpressure: o_ready only in DATA; i_valid low stalls DATA/DRAIN one-for-one; starts/words outside their window are dropped and flagged.
//
// Ports: i_clock/i_reset (async, active high); i_valid datapath enable; i_msg_start/i_n_words/i_length_aad start a message;
//        i_word_valid/o_ready payload handshake; i_tag_mismatch verdict input; o_sop, o_length_*, o_busy, o_tag_check,
//        o_auth_fail (held verdict), o_err_protocol (1-cycle violation pulse).
module gcm_msg_sequencer #(
    parameter int NB_BLOCK    = 128,
    parameter int N_BLOCKS    = 2,
    parameter int NB_DATA     = N_BLOCKS * NB_BLOCK,
    parameter int NB_LENGTH   = 64,
    parameter int NB_WORD_CNT = 16,
    parameter int TAG_LATENCY = 40
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_msg_start,
    input  logic [NB_WORD_CNT-1:0] i_n_words,
    input  logic [NB_LENGTH-1:0]   i_length_aad,
    input  logic                   i_word_valid,
    input  logic                   i_tag_mismatch,
    output logic                   o_ready,
    output logic                   o_sop,
    output logic [NB_LENGTH-1:0]   o_length_aad,
    output logic [NB_LENGTH-1:0]   o_length_plaintext,
    output logic                   o_busy,
    output logic                   o_tag_check,
    output logic                   o_auth_fail,
    output logic                   o_err_protocol
);

    // TAG_LATENCY is bounded to 1..255, so an 8-bit drain counter suffices.
    localparam int                   NB_LAT    = 8;
    localparam logic [NB_LAT-1:0]    LAT_INIT  = NB_LAT'(TAG_LATENCY);
    localparam logic [NB_LENGTH-1:0] DATA_BITS = NB_LENGTH'(NB_DATA);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t                 state;
    logic [NB_WORD_CNT-1:0] remaining;
    logic [NB_LAT-1:0]      lat_cnt;
    logic                   first_word;

    logic accept_word;
    logic start_busy;
    logic word_outside;

    assign accept_word  = i_valid & i_word_valid & (state == DATA);
    // CHECK counts as busy, so a start there is ignored and flagged too.
    assign start_busy   = i_valid & i_msg_start & (state != IDLE);
    assign word_outside = i_valid & i_word_valid & (state != DATA);

    // Pure decodes of the state register; all zero while in IDLE / reset.
    assign o_ready     = (state == DATA);
    assign o_busy      = (state != IDLE);
    assign o_tag_check = (state == CHECK);
    assign o_sop       = first_word & accept_word;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state              <= IDLE;
            remaining          <= '0;
            lat_cnt            <= '0;
            first_word         <= 1'b0;
            o_length_aad       <= '0;
            o_length_plaintext <= '0;
            o_auth_fail        <= 1'b0;
            o_err_protocol     <= 1'b0;
        end else begin
            // Both violations in one cycle merge into a single pulse.
            o_err_protocol <= start_busy | word_outside;

            case (state)
                IDLE: begin
                    if (i_valid && i_msg_start) begin
                        o_length_aad       <= i_length_aad;
                        o_length_plaintext <= NB_LENGTH'(i_n_words) * DATA_BITS;
                        o_auth_fail        <= 1'b0;
                        first_word         <= 1'b1;
                        if (i_n_words != '0) begin
                            remaining <= i_n_words;
                            state     <= DATA;
                        end else begin
                            lat_cnt <= LAT_INIT;
                            state   <= DRAIN;
                        end
                    end
                end
                DATA: begin
                    if (accept_word) begin
                        first_word <= 1'b0;
                        remaining  <= remaining - NB_WORD_CNT'(1);
                        if (remaining == NB_WORD_CNT'(1)) begin
                            lat_cnt <= LAT_INIT;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Only valid cycles advance the tag pipeline.
                    if (i_valid) begin
                        lat_cnt <= lat_cnt - NB_LAT'(1);
                        if (lat_cnt == NB_LAT'(1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // Tag comparison is stable now; capture it regardless of i_valid.
                    o_auth_fail <= i_tag_mismatch;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_msg_sequencer.sv
// Scoreboard bench for gcm_msg_sequencer: a transaction-level driver predicts event cycles and held values,
// a negedge monitor pops and compares when the DUT raises o_sop / o_tag_check / o_err_protocol.
// Runs directed framing, stall, error and reset cases, then randomized messages.
module tb_gcm_msg_sequencer;

    localparam int TL = 4;
    localparam int NBD = 256;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_msg_start = 1'b0;
    logic [15:0] i_n_words = '0;
    logic [63:0] i_length_aad = '0;
    logic        i_word_valid = 1'b0;
    logic        i_tag_mismatch = 1'b0;
    logic        o_ready, o_sop, o_busy, o_tag_check, o_auth_fail, o_err_protocol;
    logic [63:0] o_length_aad, o_length_plaintext;

    gcm_msg_sequencer #(.TAG_LATENCY(TL)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_msg_start(i_msg_start),
        .i_n_words(i_n_words), .i_length_aad(i_length_aad), .i_word_valid(i_word_valid),
        .i_tag_mismatch(i_tag_mismatch), .o_ready(o_ready), .o_sop(o_sop),
        .o_length_aad(o_length_aad), .o_length_plaintext(o_length_plaintext), .o_busy(o_busy),
        .o_tag_check(o_tag_check), .o_auth_fail(o_auth_fail), .o_err_protocol(o_err_protocol)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    // Expected event cycles (scoreboard) and expected held values (model).
    int sop_q[$];
    int chk_q[$];
    int err_q[$];
    logic        exp_busy = 0, exp_ready = 0, exp_auth = 0;
    logic [63:0] exp_aad = '0, exp_pt = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int q_size(input int k);
        case (k)
            0:       return sop_q.size();
            1:       return chk_q.size();
            default: return err_q.size();
        endcase
    endfunction

    function automatic int q_front(input int k);
        case (k)
            0:       return sop_q[0];
            1:       return chk_q[0];
            default: return err_q[0];
        endcase
    endfunction

    function automatic void q_pop(input int k);
        case (k)
            0:       void'(sop_q.pop_front());
            1:       void'(chk_q.pop_front());
            default: void'(err_q.pop_front());
        endcase
    endfunction

    task automatic ev(input int k, input logic seen, input string nm);
        while (q_size(k) > 0 && q_front(k) < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s missing: expected at cycle %0d, not seen by cycle %0d", nm, q_front(k), cyc);
            q_pop(k);
        end
        if (seen === 1'b1) begin
            n_tests++;
            if (q_size(k) > 0 && q_front(k) == cyc) begin
                q_pop(k);
            end else begin
                n_fail++;
                $display("FAIL %s unexpected: seen at cycle %0d, next expected %0d", nm, cyc,
                         q_size(k) > 0 ? q_front(k) : -1);
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge i_clock) begin
        if (started) begin
            ev(0, o_sop, "sop");
            ev(1, o_tag_check, "tag_check");
            ev(2, o_err_protocol, "err_protocol");
            chk("busy", 64'(o_busy), 64'(exp_busy));
            chk("ready", 64'(o_ready), 64'(exp_ready));
            chk("auth_fail", 64'(o_auth_fail), 64'(exp_auth));
            chk("length_aad", o_length_aad, exp_aad);
            chk("length_plaintext", o_length_plaintext, exp_pt);
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_in();
        i_valid = 0; i_msg_start = 0; i_word_valid = 0; i_tag_mismatch = 0;
    endtask

    task automatic idle(input int ncyc, input bit errs);
        for (int i = 0; i < ncyc; i++) begin
            i_valid        = $urandom_range(0, 1);
            i_word_valid   = errs && ($urandom_range(0, 3) == 0);
            i_msg_start    = 0;
            i_tag_mismatch = $urandom_range(0, 1);
            if (i_valid && i_word_valid) err_q.push_back(cyc + 1);
            tick();
        end
        clear_in();
    endtask

    task automatic check_all_zero();
        chk("rst ready", 64'(o_ready), 0);
        chk("rst sop", 64'(o_sop), 0);
        chk("rst busy", 64'(o_busy), 0);
        chk("rst tag_check", 64'(o_tag_check), 0);
        chk("rst auth_fail", 64'(o_auth_fail), 0);
        chk("rst err_protocol", 64'(o_err_protocol), 0);
        chk("rst length_aad", o_length_aad, 0);
        chk("rst length_plaintext", o_length_plaintext, 0);
    endtask

    // One message: start, n words, TL valid drain cycles, one CHECK cycle.
    // pvalid = percent of cycles with i_valid high; errs injects protocol violations;
    // abort >= 0 asserts reset asynchronously after that many valid drain cycles.
    task automatic run_msg(input int n, input logic [63:0] aad, input bit mm,
                           input int pvalid, input bit errs, input int abort);
        int acc = 0;
        int vcnt = 0;
        int guard = 0;
        logic [63:0] pt;
        pt = 64'(n) * 64'(NBD);
        i_valid = 1; i_msg_start = 1; i_word_valid = 0;
        i_n_words = 16'(n); i_length_aad = aad;
        i_tag_mismatch = $urandom_range(0, 1);
        tick();
        exp_busy = 1; exp_ready = (n != 0); exp_aad = aad; exp_pt = pt; exp_auth = 0;
        i_msg_start = 0;

        while (acc < n) begin
            i_valid        = ($urandom_range(0, 99) < pvalid);
            i_word_valid   = $urandom_range(0, 1);
            i_msg_start    = errs && ($urandom_range(0, 4) == 0);
            i_n_words      = 16'($urandom);
            i_length_aad   = {$urandom, $urandom};
            i_tag_mismatch = $urandom_range(0, 1);
            if (i_valid && i_msg_start) err_q.push_back(cyc + 1);
            if (i_valid && i_word_valid) begin
                if (acc == 0) sop_q.push_back(cyc);
                acc++;
            end
            tick();
            if (acc == n) exp_ready = 0;
            if (++guard > 2000) begin
                n_tests++; n_fail++;
                $display("FAIL data_phase timeout: got %0d words expected %0d", acc, n);
                break;
            end
        end

        guard = 0;
        while (vcnt < TL) begin
            if (abort >= 0 && vcnt == abort) begin
                clear_in();
                #2 i_reset = 1;
                exp_busy = 0; exp_ready = 0; exp_auth = 0; exp_aad = '0; exp_pt = '0;
                #1 check_all_zero();
                tick();
                tick();
                i_reset = 0;
                return;
            end
            i_valid        = ($urandom_range(0, 99) < pvalid);
            i_word_valid   = errs && ($urandom_range(0, 5) == 0);
            i_msg_start    = errs && ($urandom_range(0, 5) == 0);
            i_tag_mismatch = $urandom_range(0, 1);
            if (i_valid && (i_word_valid || i_msg_start)) err_q.push_back(cyc + 1);
            if (i_valid) vcnt++;
            tick();
            if (++guard > 2000) begin
                n_tests++; n_fail++;
                $display("FAIL drain_phase timeout: got %0d valid cycles expected %0d", vcnt, TL);
                break;
            end
        end

        // CHECK cycle: verdict sampled regardless of i_valid.
        i_valid        = ($urandom_range(0, 99) < pvalid);
        i_tag_mismatch = mm;
        i_word_valid   = errs && ($urandom_range(0, 3) == 0);
        i_msg_start    = errs && ($urandom_range(0, 3) == 0);
        if (i_valid && (i_word_valid || i_msg_start)) err_q.push_back(cyc + 1);
        chk_q.push_back(cyc);
        tick();
        exp_busy = 0; exp_auth = mm;
        clear_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        clear_in();
        tick();
        tick();
        check_all_zero();
        i_reset = 0;
        started = 1;
        tick();

        // Continuous-valid 3-word message: sop at t+1, check at t+8, pass verdict.
        run_msg(3, 64'd128, 0, 100, 0, -1);
        idle(3, 0);
        // Same message failing authentication; verdict held through the gap and the next start.
        run_msg(3, 64'd128, 1, 100, 0, -1);
        idle(4, 0);
        // Zero-word message: no ready, no sop, check at t+TL+1.
        run_msg(0, 64'd77, 0, 100, 0, -1);
        // Back-to-back start in the first IDLE cycle, with stalls in DATA and DRAIN.
        run_msg(2, 64'h1234, 1, 60, 0, -1);
        // Protocol violations inside the message and in idle.
        run_msg(2, 64'habcd, 0, 100, 1, -1);
        idle(6, 1);
        // Reset mid-DRAIN, then a start on the first clock after release.
        run_msg(1, 64'h55, 1, 100, 0, 2);
        run_msg(2, 64'h99, 1, 100, 0, -1);

        for (int m = 0; m < 40; m++) begin
            run_msg($urandom_range(0, 6), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    $urandom_range(40, 100), 1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        idle(8, 0);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (q_size(k) != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain q%0d: got %0d pending expected 0", k, q_size(k));
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_msg_sequencer.md
# gcm_msg_sequencer

Message-level controller for the GCM-AES decipher datapath. It frames one authenticated message at a time:
- latches the AAD and plaintext lengths;
- generates the start-of-payload strobe aligned with the first ciphertext word;
- counts payload words;
- after the fixed pipeline latency of the tag path, issues a single tag-check strobe and captures the authentication verdict.

It sits between the packet front-end and the decipher datapath, and replaces free-running tag comparison with a per-message end-of-message decision.

## Interface
Parameters:
- NB_BLOCK, 128, bits per AES block
- N_BLOCKS, 2, blocks per datapath word
- NB_DATA, N_BLOCKS*NB_BLOCK, bits per datapath word
- NB_LENGTH, 64, width of length fields (bits, GCM len() format)
- NB_WORD_CNT, 16, width of payload word count
- TAG_LATENCY, 40, valid-cycles from last accepted word to regenerated tag stable; legal range 1..255

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  datapath clock enable; pipeline advances only when high
- i_msg_start  in  1  start of message; sampled only with i_valid
- i_n_words  in  NB_WORD_CNT  payload words in message; sampled at start
- i_length_aad  in  NB_LENGTH  AAD length in bits; sampled at start
- i_word_valid  in  1  ciphertext word presented this cycle
- i_tag_mismatch  in  1  regenerated tag != received tag (combinational from datapath)
- o_ready  out  1  payload word accepted when i_valid & i_word_valid & o_ready
- o_sop  out  1  start-of-payload to datapath (combinational)
- o_length_aad  out  NB_LENGTH  latched AAD length
- o_length_plaintext  out  NB_LENGTH  i_n_words*NB_DATA, latched
- o_busy  out  1  message in progress
- o_tag_check  out  1  one-cycle strobe: verdict captured
- o_auth_fail  out  1  verdict of last message, held
- o_err_protocol  out  1  one-cycle pulse on protocol violation

## Operation
- States: IDLE, DATA, DRAIN, CHECK.
- IDLE:
  - On i_valid & i_msg_start: latch i_length_aad, i_n_words, and length = i_n_words*NB_DATA (zero-extended/truncated to NB_LENGTH).
  - Clear o_auth_fail and set first-word flag.
  - If i_n_words != 0, go to DATA with remaining = i_n_words.
  - If i_n_words == 0, go to DRAIN with counter = TAG_LATENCY.
- DATA:
  - o_ready = 1.
  - Each accepted word decrements remaining.
  - o_sop = first-word flag & i_valid & i_word_valid; the flag clears on the first accept.
  - Accept with remaining == 1: go to DRAIN, counter = TAG_LATENCY.
- DRAIN:
  - Counter decrements on each i_valid cycle.
  - When a decrement brings it to 0, go to CHECK.
- CHECK (one cycle, independent of i_valid):
  - o_tag_check = 1.
  - o_auth_fail <= i_tag_mismatch.
  - Next state IDLE.
- o_busy = (state != IDLE).
- o_err_protocol (registered, 1-cycle pulse) is raised on either violation:
  - i_valid & i_msg_start while busy: the start is ignored.
  - i_valid & i_word_valid outside DATA: the word is not accepted.
- Both violations in the same cycle produce a single pulse.
- A start in the CHECK cycle counts as busy, so it is ignored and flagged.
- o_length_* and o_auth_fail hold until the next accepted start.
- Reset (async) at any point: state IDLE, counters 0, all outputs 0. An in-flight message is abandoned with no tag check.

## Timing
- Start accepted at cycle t: o_busy = 1 and o_ready = 1 from t+1. The start cycle never carries a payload word.
- o_sop is combinational and coincident with the first accepted word.
- If the last word is accepted at cycle L, then with i_valid continuously high:
  - DRAIN occupies L+1..L+TAG_LATENCY;
  - CHECK is at L+TAG_LATENCY+1;
  - IDLE (new start accepted) from L+TAG_LATENCY+2.
- i_valid low cycles in DATA/DRAIN stall progress one-for-one.
- A zero-word message started at t gets CHECK at t+TAG_LATENCY+1 (continuous valid).
- Reset values: o_ready 0, o_sop 0, o_busy 0, o_tag_check 0, o_auth_fail 0, o_err_protocol 0, o_length_aad 0, o_length_plaintext 0.

## Test plan
- TAG_LATENCY=4, start with i_n_words=3, i_length_aad=128, i_valid always high, words on t+1..t+3:
  - o_sop only at t+1;
  - o_length_plaintext = 768;
  - o_tag_check at t+8;
  - with i_tag_mismatch=0 there, o_auth_fail = 0;
  - o_busy falls at t+9.
- Same message with i_tag_mismatch=1 only in the CHECK cycle -> o_auth_fail = 1, held until the next start, cleared the cycle after that start.
- i_n_words=0 at t, TAG_LATENCY=4 -> o_ready never asserted, o_sop never asserted, o_tag_check at t+5.
- 2-word message with i_valid low for 3 cycles inside DATA and 2 cycles inside DRAIN -> o_tag_check delayed by exactly 5 cycles vs. the continuous case; word count is unaffected.
- i_msg_start during DATA, and i_word_valid in IDLE -> one o_err_protocol pulse each; state, remaining count and lengths unchanged.
- Assert i_reset asynchronously mid-DRAIN -> all outputs 0 immediately; no o_tag_check; a new start is accepted on the first clock after reset deasserts.
